// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
// Shared types and defaults for the period meter and its edge-detect front end.
//   state_e    : measurement FSM states (IDLE waits for a first edge,
//                MEASURE counts cycles between edges).
//   DEF_*      : default parameter values for period_meter.
//   avg_count  : number of periods folded into one averaged result.
// -----------------------------------------------------------------------------
package period_meter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_TIMEOUT  = 50_000;
    localparam int unsigned DEF_AVG_LOG2 = 0;

    function automatic int unsigned avg_count(input int unsigned avg_log2);
        return 32'd1 << avg_log2;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous level into the clk_in domain through two flops and
// emits a one-cycle pulse for each rising edge of the synchronised level.
// Ports:
//   clk_in  : system clock
//   rst     : synchronous, active-low reset (clears all three flops)
//   async_i : asynchronous input level
//   level_o : synchronised level
//   edge_o  : high for one cycle after each synchronised rising edge
// -----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst,
    input  logic async_i,
    output logic level_o,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: non-blocking assignments let every flop sample its input from
    // before the clock edge, which is what makes this a real shift chain.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign edge_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures the period of a slow pulse train in clk_in cycles, averages it over
// 2^AVG_LOG2 periods and offers each result on a valid/ready output register.
// Flags a stall when no edge arrives for TIMEOUT cycles, and a lost result when
// a new one overwrites an unread one.
// Parameters:
//   WIDTH    : width of the period counter and of period
//   TIMEOUT  : cycles without an edge before timeout (2 <= TIMEOUT < 2^WIDTH)
//   AVG_LOG2 : log2 of periods averaged per result (0..4)
// Ports:
//   clk_in  : system clock
//   rst     : synchronous, active-low reset
//   sig_in  : asynchronous measured signal
//   period  : averaged period in cycles
//   valid   : period holds an unread result
//   ready   : consumer takes period this cycle (transfer when valid && ready)
//   timeout : no edge for TIMEOUT cycles; held until the next edge
//   overrun : an unread result was overwritten; cleared by a transfer
// -----------------------------------------------------------------------------
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             valid,
    input  logic             ready,
    output logic             timeout,
    output logic             overrun
);

    localparam int unsigned ACC_W = WIDTH + AVG_LOG2;
    localparam int unsigned N_W   = AVG_LOG2 + 1;

    localparam logic [N_W-1:0]   N_LAST    = N_W'(avg_count(AVG_LOG2));
    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);

    logic edge_p;
    logic level_unused;

    sync_edge_detect u_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .async_i (sig_in),
        .level_o (level_unused),
        .edge_o  (edge_p)
    );

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   count_q,   count_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;
    logic [N_W-1:0]     n_q,       n_d;
    logic [WIDTH-1:0]   period_q,  period_d;
    logic               valid_q,   valid_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;

    logic               cap;
    logic [WIDTH-1:0]   result;
    logic [ACC_W-1:0]   acc_sum;
    logic [N_W-1:0]     n_inc;

    assign acc_sum = acc_q + ACC_W'(count_q);
    assign n_inc   = n_q + N_W'(1);

    // Measurement FSM, counter and accumulator.
    // NOTE: every signal driven here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        n_d       = n_q;
        timeout_d = timeout_q;
        cap       = 1'b0;
        result    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (edge_p) begin
                    state_d   = ST_MEASURE;
                    count_d   = WIDTH'(1);
                    acc_d     = '0;
                    n_d       = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                // An edge on the same cycle count reaches TIMEOUT takes
                // priority: it closes a normal period of TIMEOUT cycles.
                if (edge_p) begin
                    count_d = WIDTH'(1);
                    if (n_inc == N_LAST) begin
                        cap    = 1'b1;
                        result = WIDTH'(acc_sum >> AVG_LOG2);
                        acc_d  = '0;
                        n_d    = '0;
                    end else begin
                        acc_d = acc_sum;
                        n_d   = n_inc;
                    end
                end else if (count_q == TIMEOUT_C) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    count_d   = '0;
                    acc_d     = '0;
                    n_d       = '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register with valid/ready handshake. A capture always wins over
    // a transfer; if the old result is being taken in the same cycle it was
    // not lost, so overrun is cleared rather than set.
    always_comb begin
        period_d  = period_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (cap) begin
            period_d = result;
            valid_d  = 1'b1;
            if (valid_q) begin
                overrun_d = ~ready;
            end
        end else if (valid_q && ready) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            n_q       <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            n_q       <= n_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
// Drives two period_meter instances (AVG_LOG2 = 0 and 2) from the same
// sig_in/ready/rst and compares every output each cycle against a reference
// model that works from edge timestamps: a period is the time between two
// detected rising edges, results are plain sums shifted right, and a stall is
// TIMEOUT cycles since the last edge.
// -----------------------------------------------------------------------------
module tb_period_meter;

    localparam int W   = 16;
    localparam int TMO = 1000;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b0;
    logic         sig_in = 1'b0;
    logic         ready  = 1'b1;

    logic [W-1:0] period_a, period_b;
    logic         valid_a, valid_b;
    logic         timeout_a, timeout_b;
    logic         overrun_a, overrun_b;

    always #5 clk_in = ~clk_in;

    period_meter #(.WIDTH(W), .TIMEOUT(TMO), .AVG_LOG2(0)) u_dut_a (
        .clk_in  (clk_in),
        .rst     (rst),
        .sig_in  (sig_in),
        .period  (period_a),
        .valid   (valid_a),
        .ready   (ready),
        .timeout (timeout_a),
        .overrun (overrun_a)
    );

    period_meter #(.WIDTH(W), .TIMEOUT(TMO), .AVG_LOG2(2)) u_dut_b (
        .clk_in  (clk_in),
        .rst     (rst),
        .sig_in  (sig_in),
        .period  (period_b),
        .valid   (valid_b),
        .ready   (ready),
        .timeout (timeout_b),
        .overrun (overrun_b)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int avg_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    int  t = 0;
    bit  hist [3];         // sig_in samples from 1, 2 and 3 cycles ago
    bit  active   [2];     // a first edge has been seen since reset/timeout
    int  last_t   [2];
    int  sum      [2];
    int  n        [2];
    int  m_period [2];
    bit  m_valid  [2];
    bit  m_tmo    [2];
    bit  m_ovr    [2];

    task automatic model_reset(input int d);
        active[d]   = 1'b0;
        last_t[d]   = 0;
        sum[d]      = 0;
        n[d]        = 0;
        m_period[d] = 0;
        m_valid[d]  = 1'b0;
        m_tmo[d]    = 1'b0;
        m_ovr[d]    = 1'b0;
    endtask

    task automatic model_step(input int d, input bit e, input bit rdy);
        bit cap = 1'b0;
        int res = 0;
        if (e) begin
            if (!active[d]) begin
                active[d] = 1'b1;
                last_t[d] = t;
                sum[d]    = 0;
                n[d]      = 0;
                m_tmo[d]  = 1'b0;
            end else begin
                sum[d]   += t - last_t[d];
                last_t[d] = t;
                n[d]++;
                if (n[d] == (1 << avg_of(d))) begin
                    cap    = 1'b1;
                    res    = sum[d] >> avg_of(d);
                    sum[d] = 0;
                    n[d]   = 0;
                end
            end
        end else if (active[d] && (t - last_t[d] == TMO)) begin
            active[d] = 1'b0;
            m_tmo[d]  = 1'b1;
        end

        if (cap) begin
            if (m_valid[d]) m_ovr[d] = !rdy;
            m_period[d] = res;
            m_valid[d]  = 1'b1;
        end else if (m_valid[d] && rdy) begin
            m_valid[d] = 1'b0;
            m_ovr[d]   = 1'b0;
        end
    endtask

    task automatic check_dut(input int d, input logic [W-1:0] p, input logic v,
                             input logic to, input logic ov);
        check($sformatf("d%0d_period",  d), p,  m_period[d]);
        check($sformatf("d%0d_valid",   d), v,  m_valid[d]);
        check($sformatf("d%0d_timeout", d), to, m_tmo[d]);
        check($sformatf("d%0d_overrun", d), ov, m_ovr[d]);
    endtask

    always @(posedge clk_in) begin : monitor
        bit e;
        t++;
        if (!rst) begin
            hist[0] = 1'b0;
            hist[1] = 1'b0;
            hist[2] = 1'b0;
            for (int d = 0; d < 2; d++) model_reset(d);
        end else begin
            e = hist[1] & ~hist[2];
            for (int d = 0; d < 2; d++) model_step(d, e, ready);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = sig_in;
        end
        #1;
        check_dut(0, period_a, valid_a, timeout_a, overrun_a);
        check_dut(1, period_b, valid_b, timeout_b, overrun_b);
    end

    // ---------------- stimulus ----------------
    bit rand_ready = 1'b0;

    task automatic hold(input bit lvl, input int cycles);
        sig_in = lvl;
        repeat (cycles) begin
            @(negedge clk_in);
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    // One rising edge followed by p-1 more cycles: consecutive calls give
    // edges exactly p cycles apart.
    task automatic run_period(input int p, input int hi = 0);
        int h;
        h = (hi < 1) ? p / 2 : hi;
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    initial begin
        int p;
        int hi;

        // Reset held with sig_in toggling, then a first edge gives no result.
        @(negedge clk_in);
        repeat (3) begin
            sig_in = ~sig_in;
            @(negedge clk_in);
        end
        sig_in = 1'b0;
        rst    = 1'b1;
        hold(1'b0, 5);
        run_period(100);

        // Steady square wave of period 100 with ready high.
        repeat (8) run_period(100);
        check("sq100_period", period_a, 100);
        hold(1'b0, 1100);
        check("idle_timeout", timeout_a, 1);

        // Averaging over four spacings.
        run_period(100);
        run_period(102);
        run_period(104);
        run_period(106);
        hold(1'b1, 50);
        check("avg4_period", period_b, 103);
        check("avg0_period", period_a, 106);

        // Timeout exactly TIMEOUT cycles after the last edge.
        hold(1'b0, 945);
        check("tmo_early", timeout_a, 0);
        hold(1'b0, 15);
        check("tmo_fired", timeout_a, 1);
        run_period(50);
        run_period(100);
        check("after_tmo_period", period_a, 50);
        check("after_tmo_clear", timeout_a, 0);

        // Overrun with ready low, then a one-cycle ready pulse.
        hold(1'b0, 1100);
        ready = 1'b0;
        run_period(100);
        run_period(200);
        run_period(100);
        check("ovr_period", period_a, 200);
        check("ovr_valid", valid_a, 1);
        check("ovr_flag", overrun_a, 1);
        ready = 1'b1;
        @(negedge clk_in);
        ready = 1'b0;
        check("ovr_xfer_valid", valid_a, 0);
        check("ovr_xfer_flag", overrun_a, 0);
        ready = 1'b1;

        // Reset in the middle of a measurement.
        hold(1'b1, 40);
        rst = 1'b0;
        hold(1'b0, 3);
        rst = 1'b1;
        hold(1'b0, 57);
        run_period(100);
        hold(1'b1, 10);
        check("rst_mid_period", period_a, 100);
        hold(1'b0, 90);

        // Spacing of exactly TIMEOUT is a period; TIMEOUT+1 is a stall.
        hold(1'b0, 1100);
        run_period(1000);
        run_period(1000);
        hold(1'b1, 5);
        check("edge_wins_period", period_a, 1000);
        check("edge_wins_no_tmo", timeout_a, 0);
        hold(1'b0, 996);
        run_period(50);
        hold(1'b1, 5);
        check("stall_then_period", period_a, 50);
        hold(1'b0, 20);

        // Randomised spacings, duty cycles, ready and occasional reset.
        rand_ready = 1'b1;
        repeat (40) begin
            p  = ($urandom_range(0, 7) == 0) ? TMO : int'($urandom_range(3, 1100));
            hi = int'($urandom_range(1, p - 2));
            run_period(p, hi);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b0;
                hold(1'b0, 2);
                rst = 1'b1;
            end
        end
        rand_ready = 1'b0;
        ready      = 1'b1;
        hold(1'b0, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
